mem_port_arbiter: RTL and testbench

- Shares one single-ported, synchronous-read memory between the pipelined CPU's instruction-fetch requester (F) and load/store requester (D).
- Sequences each access through a fixed ISSUE/RESP state machine.
- Data accesses have priority, with an anti-starvation rule for fetch.
- Halt-aware quiesce output gives the top level and bench a clean "memory idle after halt" indication.

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous-read memory port between instruction fetch (F) and load/store (D).
// Build option: define ARB_STATS_EN to get free-running F/D grant counters.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W           = 32,
    parameter int unsigned DATA_W           = 32,
    parameter int unsigned FETCH_STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halt,
    input  logic                  f_req,
    input  logic [ADDR_W-1:0]     f_addr,
    output logic                  f_ack,
    output logic [DATA_W-1:0]     f_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wmask,
    output logic                  d_ack,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  quiesced,
    output logic [31:0]           f_grant_cnt,
    output logic [31:0]           d_grant_cnt
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

    localparam int unsigned         STARVE_W   = 4;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(FETCH_STARVE_MAX);

    state_t              state;
    logic                owner_d;
    logic                owner_we;
    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_nxt;
    logic                arb_slot;
    logic                f_elig;
    logic                f_cand;
    logic                d_cand;
    logic                grant_f;
    logic                grant_d;

    // Arbitration: the access just acked cannot win again on its own ack edge.
    always_comb begin
        arb_slot   = (state == IDLE) || (state == RESP);
        f_elig     = f_req && !halt;
        f_cand     = arb_slot && f_elig && !((state == RESP) && !owner_d);
        d_cand     = arb_slot && d_req && !((state == RESP) && owner_d);
        grant_f    = f_cand && (!d_cand || (starve_cnt == STARVE_MAX));
        grant_d    = d_cand && !grant_f;
        starve_nxt = starve_cnt;
        if (!f_elig || grant_f) begin
            starve_nxt = '0;
        end else if (grant_d && (starve_cnt != STARVE_MAX)) begin
            starve_nxt = starve_cnt + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner_d    <= 1'b0;
            owner_we   <= 1'b0;
            starve_cnt <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            f_ack      <= 1'b0;
            d_ack      <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            f_ack      <= 1'b0;
            d_ack      <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    state <= IDLE;
                    if (grant_f) begin
                        state     <= ISSUE;
                        owner_d   <= 1'b0;
                        owner_we  <= 1'b0;
                        mem_en    <= 1'b1;
                        mem_addr  <= f_addr;
                        mem_wdata <= '0;
                        mem_wmask <= '0;
                    end else if (grant_d) begin
                        state     <= ISSUE;
                        owner_d   <= 1'b1;
                        owner_we  <= d_we;
                        mem_en    <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_wmask <= d_wmask;
                    end
                end
                ISSUE: begin
                    state <= RESP;
                    f_ack <= !owner_d;
                    d_ack <= owner_d;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data arrives the cycle after the strobe, i.e. exactly in the ack cycle.
    assign f_rdata  = f_ack ? mem_rdata : '0;
    assign d_rdata  = (d_ack && !owner_we) ? mem_rdata : '0;
    assign quiesced = halt && (state == IDLE);

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_grant_cnt <= '0;
            d_grant_cnt <= '0;
        end else begin
            if (grant_f) f_grant_cnt <= f_grant_cnt + 32'd1;
            if (grant_d) d_grant_cnt <= d_grant_cnt + 32'd1;
        end
    end
`else
    assign f_grant_cnt = '0;
    assign d_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int          STARVE_MAX = 4;
    localparam int          MEM_WORDS  = 256;

    logic        clk, rst, halt;
    logic        f_req, f_ack, d_req, d_we, d_ack;
    logic        mem_en, mem_we, quiesced;
    logic [31:0] f_addr, f_rdata, d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, f_grant_cnt, d_grant_cnt;
    logic [3:0]  d_wmask, mem_wmask;

    int nvec, nfail;
    logic [31:0] tb_mem  [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    int          m_age, m_starve, m_fcnt, m_dcnt;
    bit          m_owner_d, m_owner_we;
    logic [31:0] m_rdata;
    bit          e_mem_en, e_mem_we, e_f_ack, e_d_ack;
    logic [31:0] e_mem_addr, e_mem_wdata, e_f_rdata, e_d_rdata;
    logic [3:0]  e_mem_wmask;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FETCH_STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst), .halt(halt),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
        .quiesced(quiesced), .f_grant_cnt(f_grant_cnt), .d_grant_cnt(d_grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 64) return 32'hDEADBEEF;
        return (32'(i) * 32'h0101_0101) ^ 32'h5A00_00A5;
    endfunction

    // Synchronous-read memory; reloads its power-on pattern while reset is held.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < MEM_WORDS; i++) tb_mem[i] = init_word(i);
        end else if (mem_en) begin
            if (mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) tb_mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            mem_rdata <= tb_mem[mem_addr[9:2]];
        end
    end

    task automatic model_reset();
        m_age = 0; m_starve = 0; m_fcnt = 0; m_dcnt = 0;
        m_owner_d = 0; m_owner_we = 0; m_rdata = 0;
        e_mem_en = 0; e_mem_we = 0; e_f_ack = 0; e_d_ack = 0;
        e_mem_addr = 0; e_mem_wdata = 0; e_mem_wmask = 0; e_f_rdata = 0; e_d_rdata = 0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
    endtask

    // Reference: m_age counts cycles since the last grant (0 = idle, 1 = strobe cycle, 2 = ack cycle).
    task automatic model_step();
        bit fe, fc, dc, gf, gd;
        int idx;
        e_mem_en = 0; e_f_ack = 0; e_d_ack = 0; e_f_rdata = 0; e_d_rdata = 0;
        fe = f_req && !halt;
        gf = 0; gd = 0;
        if (m_age == 1) begin
            m_age = 2;
            if (m_owner_d) begin
                e_d_ack   = 1;
                e_d_rdata = m_owner_we ? 32'h0 : m_rdata;
            end else begin
                e_f_ack   = 1;
                e_f_rdata = m_rdata;
            end
        end else begin
            fc = fe && !(m_age == 2 && !m_owner_d);
            dc = d_req && !(m_age == 2 && m_owner_d);
            gf = fc && (!dc || m_starve == STARVE_MAX);
            gd = dc && !gf;
            m_age = (gf || gd) ? 1 : 0;
        end
        if (gf) begin
            idx = int'(f_addr[9:2]);
            m_owner_d = 0; m_owner_we = 0;
            e_mem_we = 0; e_mem_addr = f_addr; e_mem_wdata = 0; e_mem_wmask = 0;
            m_rdata = ref_mem[idx];
            m_fcnt++;
        end
        if (gd) begin
            idx = int'(d_addr[9:2]);
            m_owner_d = 1; m_owner_we = d_we;
            e_mem_we = d_we; e_mem_addr = d_addr; e_mem_wdata = d_wdata; e_mem_wmask = d_wmask;
            if (d_we) begin
                for (int b = 0; b < 4; b++)
                    if (d_wmask[b]) ref_mem[idx][8*b +: 8] = d_wdata[8*b +: 8];
                m_rdata = 0;
            end else begin
                m_rdata = ref_mem[idx];
            end
            m_dcnt++;
        end
        e_mem_en = gf || gd;
        if (!fe || gf) m_starve = 0;
        else if (gd && m_starve < STARVE_MAX) m_starve++;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drain();
        f_req = 0; d_req = 0;
        repeat (3) step();
    endtask

    task automatic do_access(input bit is_d, input logic [31:0] addr, output bit ok);
        ok = 0;
        if (is_d) begin d_req = 1; d_we = 0; d_addr = addr; end
        else begin f_req = 1; f_addr = addr; end
        for (int i = 0; i < 6 && !ok; i++) begin
            step();
            if ((is_d && d_ack) || (!is_d && f_ack)) ok = 1;
        end
        f_req = 0; d_req = 0;
        step();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        nvec++; if ({mem_en, mem_we, f_ack, d_ack, quiesced} !== 5'b0) begin nfail++; $display("FAIL reset_ctrl got %b exp 00000", {mem_en, mem_we, f_ack, d_ack, quiesced}); end
        nvec++; if ({mem_addr, mem_wdata, mem_wmask} !== 68'h0) begin nfail++; $display("FAIL reset_cmd got %h exp 0", {mem_addr, mem_wdata, mem_wmask}); end
        nvec++; if ({f_rdata, d_rdata} !== 64'h0) begin nfail++; $display("FAIL reset_rdata got %h exp 0", {f_rdata, d_rdata}); end
        nvec++; if ({f_grant_cnt, d_grant_cnt} !== 64'h0) begin nfail++; $display("FAIL reset_cnt got %h exp 0", {f_grant_cnt, d_grant_cnt}); end
        @(negedge clk) rst = 1;
        #1;
    endtask

    task automatic test_load_store();
        logic [31:0] exp_w;
        d_req = 1; d_we = 0; d_addr = 32'h100;
        step();
        nvec++; if ({mem_en, mem_we, d_ack} !== 3'b100 || mem_addr !== 32'h100) begin nfail++; $display("FAIL load_issue en/we/ack %b addr %h exp 100 addr 100", {mem_en, mem_we, d_ack}, mem_addr); end
        step();
        nvec++; if ({mem_en, d_ack, f_ack} !== 3'b010) begin nfail++; $display("FAIL load_ack en/dack/fack %b exp 010", {mem_en, d_ack, f_ack}); end
        nvec++; if (d_rdata !== 32'hDEADBEEF) begin nfail++; $display("FAIL load_rdata got %h exp deadbeef", d_rdata); end
        d_req = 0;
        step();
        nvec++; if ({mem_en, d_ack} !== 2'b00) begin nfail++; $display("FAIL load_pulse en/ack %b exp 00", {mem_en, d_ack}); end
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h12345678; d_wmask = 4'b0011;
        step();
        nvec++; if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 32'h40 || mem_wdata !== 32'h12345678 || mem_wmask !== 4'b0011)
            begin nfail++; $display("FAIL store_issue en/we %b addr %h wdata %h mask %b exp 11 40 12345678 0011", {mem_en, mem_we}, mem_addr, mem_wdata, mem_wmask); end
        step();
        nvec++; if (d_ack !== 1'b1 || d_rdata !== 32'h0 || mem_en !== 1'b0) begin nfail++; $display("FAIL store_ack ack %b rdata %h en %b exp 1 0 0", d_ack, d_rdata, mem_en); end
        d_req = 0;
        step();
        d_req = 1; d_we = 0; d_addr = 32'h40;
        step(); step();
        exp_w = (init_word(16) & 32'hFFFF0000) | 32'h5678;
        nvec++; if (d_ack !== 1'b1 || d_rdata !== exp_w) begin nfail++; $display("FAIL store_readback ack %b rdata %h exp 1 %h", d_ack, d_rdata, exp_w); end
        drain();
    endtask

    task automatic test_contention();
        int acks;
        acks = 0;
        f_req = 1; f_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h100; halt = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            nvec++; if ({f_ack, d_ack, mem_en} !== {e_f_ack, e_d_ack, e_mem_en} || (e_mem_en && mem_addr !== e_mem_addr))
                begin nfail++; $display("FAIL contention c%0d fack/dack/en %b addr %h exp %b %h", c, {f_ack, d_ack, mem_en}, mem_addr, {e_f_ack, e_d_ack, e_mem_en}, e_mem_addr); end
            nvec++; if (f_ack && d_ack) begin nfail++; $display("FAIL contention_dual_ack c%0d got 11 exp not both", c); end
            acks += int'(f_ack) + int'(d_ack);
        end
        nvec++; if (acks != 10) begin nfail++; $display("FAIL contention_ack_rate got %0d exp 10", acks); end
        drain();
    endtask

    task automatic test_halt();
        f_req = 1; f_addr = 32'h200; d_req = 0; halt = 0;
        step();
        nvec++; if (mem_en !== 1'b1 || mem_addr !== 32'h200) begin nfail++; $display("FAIL halt_fetch_issue en %b addr %h exp 1 200", mem_en, mem_addr); end
        halt = 1;
        step();
        nvec++; if (f_ack !== 1'b1 || f_rdata !== init_word(128) || quiesced !== 1'b0) begin nfail++; $display("FAIL halt_fetch_ack ack %b rdata %h q %b exp 1 %h 0", f_ack, f_rdata, quiesced, init_word(128)); end
        step();
        nvec++; if ({quiesced, mem_en, f_ack} !== 3'b100) begin nfail++; $display("FAIL halt_quiesce q/en/ack %b exp 100", {quiesced, mem_en, f_ack}); end
        for (int c = 0; c < 3; c++) begin
            step();
            nvec++; if ({mem_en, quiesced} !== 2'b01) begin nfail++; $display("FAIL halt_no_fetch c%0d en/q %b exp 01", c, {mem_en, quiesced}); end
        end
        d_req = 1; d_we = 0; d_addr = 32'h100;
        step();
        nvec++; if ({mem_en, quiesced} !== 2'b10 || mem_addr !== 32'h100) begin nfail++; $display("FAIL halt_data_issue en/q %b addr %h exp 10 100", {mem_en, quiesced}, mem_addr); end
        step();
        nvec++; if ({d_ack, f_ack, quiesced} !== 3'b100 || d_rdata !== 32'hDEADBEEF) begin nfail++; $display("FAIL halt_data_ack d/f/q %b rdata %h exp 100 deadbeef", {d_ack, f_ack, quiesced}, d_rdata); end
        d_req = 0;
        step();
        nvec++; if (quiesced !== 1'b1) begin nfail++; $display("FAIL halt_requiesce got %b exp 1", quiesced); end
        f_req = 0; halt = 0;
        drain();
    endtask

    task automatic test_reset_mid();
        d_req = 1; d_we = 0; d_addr = 32'h100;
        step();
        nvec++; if (mem_en !== 1'b1) begin nfail++; $display("FAIL rstmid_issue en %b exp 1", mem_en); end
        rst = 0;
        #1;
        nvec++; if ({mem_en, mem_we, f_ack, d_ack} !== 4'b0 || mem_addr !== 32'h0) begin nfail++; $display("FAIL rstmid_clear en/we/f/d %b addr %h exp 0000 0", {mem_en, mem_we, f_ack, d_ack}, mem_addr); end
        model_reset();
        @(posedge clk);
        #1;
        nvec++; if ({d_ack, mem_en} !== 2'b00) begin nfail++; $display("FAIL rstmid_noack ack/en %b exp 00", {d_ack, mem_en}); end
        @(negedge clk) rst = 1;
        step();
        nvec++; if (mem_en !== 1'b1 || mem_addr !== 32'h100) begin nfail++; $display("FAIL rstmid_regrant en %b addr %h exp 1 100", mem_en, mem_addr); end
        step();
        nvec++; if (d_ack !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin nfail++; $display("FAIL rstmid_ack ack %b rdata %h exp 1 deadbeef", d_ack, d_rdata); end
        drain();
    endtask

    task automatic test_stats();
        bit ok;
        logic [31:0] ef, ed;
        @(negedge clk) rst = 0;
        model_reset();
        @(posedge clk);
        @(negedge clk) rst = 1;
        for (int i = 0; i < 8; i++) begin
            do_access(i >= 3, 32'(i * 8), ok);
            nvec++; if (!ok) begin nfail++; $display("FAIL stats_access%0d no ack within 6 cycles", i); end
        end
`ifdef ARB_STATS_EN
        ef = 32'd3; ed = 32'd5;
`else
        ef = 32'd0; ed = 32'd0;
`endif
        nvec++; if (f_grant_cnt !== ef || d_grant_cnt !== ed) begin nfail++; $display("FAIL stats_counts f %0d d %0d exp %0d %0d", f_grant_cnt, d_grant_cnt, ef, ed); end
    endtask

    task automatic test_random();
        bit e_q;
        logic [31:0] ef, ed;
        for (int c = 0; c < 3000; c++) begin
            step();
            e_q = halt && (m_age == 0);
            nvec++; if ({mem_en, f_ack, d_ack, quiesced} !== {e_mem_en, e_f_ack, e_d_ack, e_q})
                begin nfail++; $display("FAIL rand_ctrl c%0d en/f/d/q %b exp %b", c, {mem_en, f_ack, d_ack, quiesced}, {e_mem_en, e_f_ack, e_d_ack, e_q}); end
            nvec++; if (f_rdata !== e_f_rdata || d_rdata !== e_d_rdata)
                begin nfail++; $display("FAIL rand_rdata c%0d f %h d %h exp %h %h", c, f_rdata, d_rdata, e_f_rdata, e_d_rdata); end
            if (e_mem_en) begin
                nvec++; if (mem_addr !== e_mem_addr || mem_we !== e_mem_we)
                    begin nfail++; $display("FAIL rand_cmd c%0d addr %h we %b exp %h %b", c, mem_addr, mem_we, e_mem_addr, e_mem_we); end
                if (e_mem_we) begin
                    nvec++; if (mem_wdata !== e_mem_wdata || mem_wmask !== e_mem_wmask)
                        begin nfail++; $display("FAIL rand_wr c%0d wdata %h mask %b exp %h %b", c, mem_wdata, mem_wmask, e_mem_wdata, e_mem_wmask); end
                end
                // Fields may change once granted; the in-flight access must not notice.
                if (m_owner_d) begin d_addr = $urandom_range(0, 1023); d_wdata = $urandom; d_we = 1'($urandom_range(0, 1)); d_wmask = 4'($urandom); end
                else f_addr = $urandom_range(0, 1023);
            end
            if (f_ack) f_req = 0;
            if (d_ack) d_req = 0;
            if (!f_req && $urandom_range(0, 2) == 0) begin f_req = 1; f_addr = $urandom_range(0, 1023); end
            if (!d_req && $urandom_range(0, 2) != 0) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom_range(0, 1023);
                d_wdata = $urandom; d_wmask = 4'($urandom);
            end
            if ($urandom_range(0, 15) == 0) halt = !halt;
        end
`ifdef ARB_STATS_EN
        ef = 32'(m_fcnt); ed = 32'(m_dcnt);
`else
        ef = 32'd0; ed = 32'd0;
`endif
        nvec++; if (f_grant_cnt !== ef || d_grant_cnt !== ed) begin nfail++; $display("FAIL rand_counts f %0d d %0d exp %0d %0d", f_grant_cnt, d_grant_cnt, ef, ed); end
        halt = 0;
        drain();
    endtask

    initial begin
        nvec = 0; nfail = 0;
        rst = 0; halt = 0; f_req = 0; f_addr = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wmask = 0;
        model_reset();
        test_reset();
        test_load_store();
        test_contention();
        test_halt();
        test_reset_mid();
        test_stats();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
